// File: rtl/capture_controller_if.sv
// capture_controller_if
//   Write-side FIFO bus between the capture controller and the sample FIFO.
//   Signals:
//     fifo_din   [15:0] : write data, driven by the controller
//     fifo_wr_en        : one-cycle write strobe per word, driven by the controller
//     fifo_full         : FIFO full flag, driven by the FIFO
//   Modports:
//     master : controller side (drives din/wr_en, observes full)
//     slave  : FIFO side (observes din/wr_en, drives full)
interface capture_controller_if;
  logic [15:0] fifo_din;
  logic        fifo_wr_en;
  logic        fifo_full;

  modport master (
    output fifo_din,
    output fifo_wr_en,
    input  fifo_full
  );

  modport slave (
    input  fifo_din,
    input  fifo_wr_en,
    output fifo_full
  );
endinterface

// File: rtl/capture_controller.sv
// capture_controller
//   Sequences sample acquisition into the sample FIFO, in the sampling clock
//   domain. A programmable divider paces sample ticks; each tick packs 16, 8
//   or 4 probe channels into the next slot of a 16-bit word. Completed words
//   pass through a one-word pending stage and are then written to the FIFO.
//   A full FIFO at word completion drops the word and parks the controller
//   in OVERFLOW until the next start.
//   Ports:
//     clk, rst_n       : sampling clock, async active-low reset
//     start, stop      : one-cycle control pulses (already synchronized)
//     divider          : tick every divider+1 clocks, latched on start
//     width_sel        : 00/11 = 16 ch, 01 = 8 ch, 10 = 4 ch, latched on start
//     probes           : probe inputs (already synchronized)
//     fifo             : FIFO write-side bus (master modport)
//     running          : high while capturing
//     overflow         : sticky dropped-word flag, cleared on start
//     sample_count     : saturating count of ticks since the last start
module capture_controller #(
  parameter int DIV_WIDTH = 24
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  stop,
  input  logic [DIV_WIDTH-1:0]  divider,
  input  logic [1:0]            width_sel,
  input  logic [15:0]           probes,
  capture_controller_if.master  fifo,
  output logic                  running,
  output logic                  overflow,
  output logic [31:0]           sample_count
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_RUN      = 2'b01,
    ST_FLUSH    = 2'b10,
    ST_OVERFLOW = 2'b11
  } state_e;

  // Latched channel mode, normalised so that 2'b11 is never stored.
  localparam logic [1:0] MODE_16 = 2'b00;
  localparam logic [1:0] MODE_8  = 2'b01;
  localparam logic [1:0] MODE_4  = 2'b10;

  state_e               state_q,        state_d;
  logic [DIV_WIDTH-1:0] div_q,          div_d;
  logic [DIV_WIDTH-1:0] cnt_q,          cnt_d;
  logic [1:0]           mode_q,         mode_d;
  logic [1:0]           slot_q,         slot_d;
  logic [15:0]          pack_q,         pack_d;
  logic [15:0]          pend_word_q,    pend_word_d;
  logic                 pend_vld_q,     pend_vld_d;
  logic [15:0]          fifo_din_q,     fifo_din_d;
  logic                 fifo_wr_en_q,   fifo_wr_en_d;
  logic                 running_q,      running_d;
  logic                 overflow_q,     overflow_d;
  logic [31:0]          sample_count_q, sample_count_d;

  logic                 tick_s;
  logic [15:0]          merged_s;
  logic [1:0]           last_slot_s;

  assign tick_s = (state_q == ST_RUN) && (cnt_q == {DIV_WIDTH{1'b0}});

  // Pack register with the current probe sample merged into the active slot.
  always_comb begin
    merged_s    = pack_q;
    last_slot_s = 2'd0;
    case (mode_q)
      MODE_8: begin
        merged_s[{slot_q[0], 3'b000} +: 8] = probes[7:0];
        last_slot_s                        = 2'd1;
      end
      MODE_4: begin
        merged_s[{slot_q, 2'b00} +: 4] = probes[3:0];
        last_slot_s                    = 2'd3;
      end
      default: begin
        merged_s    = probes;
        last_slot_s = 2'd0;
      end
    endcase
  end

  // Next-state logic for the capture FSM, pack/pending stages and outputs.
  always_comb begin
    state_d        = state_q;
    div_d          = div_q;
    cnt_d          = cnt_q;
    mode_d         = mode_q;
    slot_d         = slot_q;
    pack_d         = pack_q;
    pend_word_d    = pend_word_q;
    pend_vld_d     = 1'b0;
    running_d      = running_q;
    overflow_d     = overflow_q;
    sample_count_d = sample_count_q;

    // Output stage: a pending word completed on the previous edge goes out now.
    fifo_wr_en_d = pend_vld_q;
    if (pend_vld_q) begin
      fifo_din_d = pend_word_q;
    end else begin
      fifo_din_d = fifo_din_q;
    end

    case (state_q)
      ST_IDLE, ST_OVERFLOW: begin
        // stop has priority over start; overflow is left untouched by stop.
        if (stop) begin
          state_d = ST_IDLE;
        end else if (start) begin
          state_d        = ST_RUN;
          div_d          = divider;
          mode_d         = (width_sel == 2'b11) ? MODE_16 : width_sel;
          cnt_d          = {DIV_WIDTH{1'b0}};
          slot_d         = 2'd0;
          pack_d         = 16'h0000;
          running_d      = 1'b1;
          overflow_d     = 1'b0;
          sample_count_d = 32'h0000_0000;
        end else begin
          state_d = state_q;
        end
      end

      ST_RUN: begin
        if (stop) begin
          // A tick coinciding with stop is discarded.
          running_d = 1'b0;
          if (slot_q == 2'd0) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_FLUSH;
          end
        end else begin
          if (cnt_q == div_q) begin
            cnt_d = {DIV_WIDTH{1'b0}};
          end else begin
            cnt_d = cnt_q + {{(DIV_WIDTH-1){1'b0}}, 1'b1};
          end

          if (tick_s) begin
            if (sample_count_q != 32'hFFFF_FFFF) begin
              sample_count_d = sample_count_q + 32'd1;
            end else begin
              sample_count_d = sample_count_q;
            end

            if (slot_q == last_slot_s) begin
              // Word complete: full is only consulted on this edge.
              slot_d = 2'd0;
              pack_d = 16'h0000;
              if (fifo.fifo_full) begin
                state_d    = ST_OVERFLOW;
                running_d  = 1'b0;
                overflow_d = 1'b1;
              end else begin
                pend_word_d = merged_s;
                pend_vld_d  = 1'b1;
              end
            end else begin
              pack_d = merged_s;
              slot_d = slot_q + 2'd1;
            end
          end else begin
            pack_d = pack_q;
          end
        end
      end

      ST_FLUSH: begin
        // Unfilled slots of pack_q are already zero.
        state_d = ST_IDLE;
        slot_d  = 2'd0;
        pack_d  = 16'h0000;
        if (fifo.fifo_full) begin
          overflow_d = 1'b1;
        end else begin
          pend_word_d = pack_q;
          pend_vld_d  = 1'b1;
        end
      end

      default: begin
        state_d   = ST_IDLE;
        running_d = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      div_q          <= {DIV_WIDTH{1'b0}};
      cnt_q          <= {DIV_WIDTH{1'b0}};
      mode_q         <= MODE_16;
      slot_q         <= 2'd0;
      pack_q         <= 16'h0000;
      pend_word_q    <= 16'h0000;
      pend_vld_q     <= 1'b0;
      fifo_din_q     <= 16'h0000;
      fifo_wr_en_q   <= 1'b0;
      running_q      <= 1'b0;
      overflow_q     <= 1'b0;
      sample_count_q <= 32'h0000_0000;
    end else begin
      state_q        <= state_d;
      div_q          <= div_d;
      cnt_q          <= cnt_d;
      mode_q         <= mode_d;
      slot_q         <= slot_d;
      pack_q         <= pack_d;
      pend_word_q    <= pend_word_d;
      pend_vld_q     <= pend_vld_d;
      fifo_din_q     <= fifo_din_d;
      fifo_wr_en_q   <= fifo_wr_en_d;
      running_q      <= running_d;
      overflow_q     <= overflow_d;
      sample_count_q <= sample_count_d;
    end
  end

  assign fifo.fifo_din   = fifo_din_q;
  assign fifo.fifo_wr_en = fifo_wr_en_q;
  assign running         = running_q;
  assign overflow        = overflow_q;
  assign sample_count    = sample_count_q;

endmodule

// File: tb/tb_capture_controller.sv
module tb_capture_controller;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        stop;
  logic [23:0] divider;
  logic [1:0]  width_sel;
  logic [15:0] probes;
  logic        running;
  logic        overflow;
  logic [31:0] sample_count;

  int vectors;
  int miscompares;

  logic [15:0] wr_log[$];

  capture_controller_if fif ();

  capture_controller #(.DIV_WIDTH(24)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .stop         (stop),
    .divider      (divider),
    .width_sel    (width_sel),
    .probes       (probes),
    .fifo         (fif),
    .running      (running),
    .overflow     (overflow),
    .sample_count (sample_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every FIFO write, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst_n && fif.fifo_wr_en) wr_log.push_back(fif.fifo_din);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic nclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    start       = 1'b0;
    stop        = 1'b0;
    divider     = 24'd0;
    width_sel   = 2'b00;
    probes      = 16'h0000;
    fif.fifo_full = 1'b0;

    // ---- Reset with random inputs ----
    for (int i = 0; i < 4; i++) begin
      start = 1'($urandom); stop = 1'($urandom);
      divider = 24'($urandom); width_sel = 2'($urandom);
      probes = 16'($urandom); fif.fifo_full = 1'($urandom);
      nclk(1);
    end
    check("rst_din",     32'(fif.fifo_din),   32'h0);
    check("rst_wr_en",   32'(fif.fifo_wr_en), 32'h0);
    check("rst_running", 32'(running),        32'h0);
    check("rst_ovf",     32'(overflow),       32'h0);
    check("rst_count",   sample_count,        32'h0);
    start = 1'b0; stop = 1'b0; fif.fifo_full = 1'b0;
    rst_n = 1'b1;
    nclk(2);
    check("idle_running", 32'(running), 32'h0);

    // ---- 16 ch, D=0: full throughput ----
    wr_log.delete();
    start = 1'b1; divider = 24'd0; width_sel = 2'b00; probes = 16'hA5C3;
    nclk(1);                                   // start accepted
    start = 1'b0;
    check("t1_running", 32'(running), 32'h1);
    check("t1_wr0",     32'(fif.fifo_wr_en), 32'h0);
    nclk(1);                                   // first tick
    check("t1_wr1",     32'(fif.fifo_wr_en), 32'h0);
    check("t1_cnt1",    sample_count, 32'd1);
    probes = 16'h1111;
    nclk(1);
    check("t1_wr2",     32'(fif.fifo_wr_en), 32'h1);
    check("t1_din2",    32'(fif.fifo_din),   32'hA5C3);
    probes = 16'h2222;
    nclk(1);
    check("t1_wr3",     32'(fif.fifo_wr_en), 32'h1);
    check("t1_din3",    32'(fif.fifo_din),   32'h1111);
    stop = 1'b1;
    nclk(1);
    stop = 1'b0;
    check("t1_wr4",     32'(fif.fifo_wr_en), 32'h1);
    check("t1_din4",    32'(fif.fifo_din),   32'h2222);
    check("t1_stopped", 32'(running), 32'h0);
    check("t1_cnt",     sample_count, 32'd3);
    nclk(1);
    check("t1_wr5",     32'(fif.fifo_wr_en), 32'h0);
    check("t1_nwr",     32'(wr_log.size()), 32'd3);

    // ---- 8 ch, D=2, with an ignored start during RUN ----
    wr_log.delete();
    start = 1'b1; divider = 24'd2; width_sel = 2'b01; probes = 16'hFF11;
    nclk(1);
    start = 1'b0;
    check("t2_cnt0", sample_count, 32'd0);
    nclk(1);                                   // tick, slot 0 = 0x11
    probes = 16'hEE22;
    nclk(3);                                   // tick, slot 1 = 0x22, word done
    check("t2_cnt2", sample_count, 32'd2);
    nclk(1);
    check("t2_wr_a",  32'(fif.fifo_wr_en), 32'h1);
    check("t2_din_a", 32'(fif.fifo_din),   32'h2211);
    start = 1'b1; divider = 24'd0; width_sel = 2'b00;
    nclk(1);
    start = 1'b0;
    check("t2_gap0", 32'(fif.fifo_wr_en), 32'h0);
    for (int i = 1; i <= 4; i++) begin
      nclk(1);
      check($sformatf("t2_gap%0d", i), 32'(fif.fifo_wr_en), 32'h0);
    end
    nclk(1);
    check("t2_wr_b",  32'(fif.fifo_wr_en), 32'h1);
    check("t2_din_b", 32'(fif.fifo_din),   32'h2222);
    check("t2_cnt4",  sample_count, 32'd4);
    stop = 1'b1;
    nclk(1);
    stop = 1'b0;
    check("t2_stopped", 32'(running), 32'h0);
    nclk(1);
    check("t2_nwr", 32'(wr_log.size()), 32'd2);

    // ---- 4 ch, D=0, three nibbles then stop -> FLUSH ----
    wr_log.delete();
    start = 1'b1; divider = 24'd0; width_sel = 2'b10; probes = 16'hABC1;
    nclk(1);
    start = 1'b0;
    nclk(1);                                   // nibble 1
    probes = 16'h5552; fif.fifo_full = 1'b1;   // full on a non-completion tick
    nclk(1);                                   // nibble 2
    fif.fifo_full = 1'b0; probes = 16'h9993;
    nclk(1);                                   // nibble 3
    stop = 1'b1;
    nclk(1);                                   // into FLUSH
    stop = 1'b0;
    check("t3_running", 32'(running), 32'h0);
    check("t3_wr0",     32'(fif.fifo_wr_en), 32'h0);
    nclk(1);
    check("t3_wr1",     32'(fif.fifo_wr_en), 32'h0);
    nclk(1);
    check("t3_wr2",     32'(fif.fifo_wr_en), 32'h1);
    check("t3_din2",    32'(fif.fifo_din),   32'h0321);
    nclk(1);
    check("t3_wr3",     32'(fif.fifo_wr_en), 32'h0);
    check("t3_ovf",     32'(overflow), 32'h0);
    check("t3_cnt",     sample_count, 32'd3);
    check("t3_nwr",     32'(wr_log.size()), 32'd1);

    // ---- Overflow on third completion, then restart ----
    wr_log.delete();
    start = 1'b1; divider = 24'd0; width_sel = 2'b00; probes = 16'h0001;
    nclk(1);
    start = 1'b0;
    nclk(1);                                   // word 0x0001
    probes = 16'h0002;
    nclk(1);                                   // word 0x0002
    probes = 16'h0003; fif.fifo_full = 1'b1;
    nclk(1);                                   // word 0x0003 dropped
    fif.fifo_full = 1'b0;
    check("t4_ovf",     32'(overflow), 32'h1);
    check("t4_running", 32'(running),  32'h0);
    check("t4_din",     32'(fif.fifo_din), 32'h0002);
    nclk(1);
    check("t4_wr_after", 32'(fif.fifo_wr_en), 32'h0);
    check("t4_cnt",      sample_count, 32'd3);
    nclk(2);
    check("t4_nwr",      32'(wr_log.size()), 32'd2);
    stop = 1'b1;
    nclk(1);
    stop = 1'b0;
    check("t4_ovf_kept", 32'(overflow), 32'h1);
    start = 1'b1; probes = 16'h00F0;
    nclk(1);
    start = 1'b0;
    check("t4_ovf_clr",  32'(overflow), 32'h0);
    check("t4_rerun",    32'(running),  32'h1);
    check("t4_cnt_clr",  sample_count,  32'd0);
    nclk(2);
    check("t4_wr_re",    32'(fif.fifo_wr_en), 32'h1);
    check("t4_din_re",   32'(fif.fifo_din),   32'h00F0);
    stop = 1'b1;
    nclk(1);
    stop = 1'b0;
    check("t4_cnt_re",   sample_count, 32'd2);
    nclk(1);
    check("t4_nwr_re",   32'(wr_log.size()), 32'd4);
    check("t4_log0",     32'(wr_log[0]), 32'h0001);
    check("t4_log1",     32'(wr_log[1]), 32'h0002);
    check("t4_log3",     32'(wr_log[3]), 32'h00F0);

    // ---- Simultaneous start and stop in IDLE ----
    wr_log.delete();
    start = 1'b1; stop = 1'b1; probes = 16'h7777;
    nclk(1);
    start = 1'b0; stop = 1'b0;
    check("t5_running", 32'(running), 32'h0);
    check("t5_cnt",     sample_count, 32'd2);
    nclk(3);
    check("t5_nwr",     32'(wr_log.size()), 32'd0);

    // ---- Reset mid-word ----
    wr_log.delete();
    start = 1'b1; divider = 24'd0; width_sel = 2'b01; probes = 16'h0077;
    nclk(1);
    start = 1'b0;
    nclk(1);                                   // slot 0 filled
    rst_n = 1'b0;
    #1;
    check("t6_running", 32'(running),        32'h0);
    check("t6_cnt",     sample_count,        32'h0);
    check("t6_wr",      32'(fif.fifo_wr_en), 32'h0);
    nclk(2);
    rst_n = 1'b1;
    nclk(3);
    check("t6_nwr",     32'(wr_log.size()), 32'd0);
    check("t6_idle",    32'(running),       32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
